decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  - RV32I decode stage, directly upstream of register_file and feeding execute.
//  - Accepts fetched instructions over a valid/ready handshake.
//  - Drives rs1/rs2 read addresses to register_file and captures its registered read data.
//  - Emits one decoded bundle per instruction: operands, immediate, control fields, 1-cycle latency.
//  - Owns the write-back bypass that register_file lacks: a same-edge write returns stale data.
// PARAMETERS
//  - XLEN       32            datapath width
//  - RESET_PC   32'h0000_0000 value of out_pc while empty after reset
// PORTS
//  clk           in   1   clock, rising edge
//  rstN          in   1   asynchronous active-low reset
//  in_valid      in   1   fetch presents an instruction
//  in_ready      out  1   stage can accept this cycle
//  in_instr      in   32  instruction word
//  in_pc         in   32  instruction address
//  rf_rs1        out  5   to register_file.rs1
//  rf_rs2        out  5   to register_file.rs2
//  rf_data1      in   32  from register_file.data_out1 (registered, 1 cycle)
//  rf_data2      in   32  from register_file.data_out2
//  wb_we         in   1   write-back enable (same signal driving register_file.we)
//  wb_rd         in   5   write-back destination
//  wb_data       in   32  write-back data
//  flush         in   1   discard held instruction (branch/trap redirect)
//  out_valid     out  1   decoded bundle valid
//  out_ready     in   1   execute accepts bundle
//  out_pc        out  32  pc of held instruction
//  out_rs1_val   out  32  operand 1, bypass-corrected
//  out_rs2_val   out  32  operand 2, bypass-corrected
//  out_imm       out  32  sign-extended immediate (I/S/B/U/J by opcode; 0 for R)
//  out_rd        out  5   destination; forced 0 when instruction writes no register
//  out_opcode    out  7   instr[6:0]
//  out_funct3    out  3   instr[14:12]
//  out_funct7b5  out  1   instr[30]
// BEHAVIOUR
//  - State: EMPTY / FULL (1 bit). Reset: EMPTY, all out_* = 0, out_pc = RESET_PC, held instr = 0.
//  - in_ready = EMPTY | out_ready. Accept = in_valid & in_ready.
//  - Accept: latch instr/pc at edge; state -> FULL; out_valid next cycle.
//  - FULL & out_ready & !accept -> EMPTY. FULL & out_ready & accept -> FULL, new instruction.
//  - flush (highest priority): next state EMPTY, accept suppressed, in_ready forced 0 that cycle.
//  - rf_rs1/rf_rs2 combinational: from in_instr when accept, else from held instr.
//  - Held instr re-reads register_file every cycle, so stalled operands track writes.
//  - Bypass: at each edge, register hitN = wb_we & wb_rd!=0 & wb_rd==rf_rsN, and register wb_data.
//  - out_rsN_val = hitN ? captured wb_data : rf_dataN.
//  - rs field 0 always yields 0, including when wb_rd==0.
//  - out_rd = 0 for STORE, BRANCH, and FENCE/SYSTEM opcodes.
//  - Bundle is stable while out_valid & !out_ready.
//  - Reset mid-operation: immediate return to EMPTY; the in-flight instruction is lost.
// CONFIGURATION
//  - DECODE_ILLEGAL_EN defined:
//    - adds output out_illegal (1 bit).
//    - out_illegal is high for unknown opcode, bad funct3, or funct7 other than 0/0x20 on OP.
//    - out_illegal is also high for instr[1:0]!=2'b11.
//    - on illegal: out_rd forced 0.
//  - DECODE_ILLEGAL_EN undefined: port absent; unknown encodings decode with imm=0 and rd passed through.
// STRUCTURE
//  - rv32i_pkg holds:
//    - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM).
//    - typedef enum imm_type_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
//    - typedef struct decode_bundle_t.
//  - One sub-module: imm_gen (combinational, instr + imm_type_e -> 32-bit immediate).
// TESTING
//  - Reset, then x5=0x1234 written; addi x6,x5,1 accepted -> 1 cycle later out_valid=1, out_rs1_val=0x1234, out_imm=1, out_rd=6.
//  - wb_we=1, wb_rd=5, wb_data=0xBEEF on the accept edge of add x7,x5,x5 -> out_rs1_val=out_rs2_val=0xBEEF (bypass).
//  - out_ready=0 for 3 cycles with write x5=0x55 in cycle 2 -> bundle held, in_ready=0, out_rs1_val becomes 0x55 after 1 cycle.
//  - Back-to-back stream with out_ready=1 -> one bundle per cycle, no bubbles, pc order preserved.
//  - sw x2,-4(x1) -> out_imm=0xFFFFFFFC, out_rd=0; jal x1,+2048 -> out_imm=0x800.
//  - Hazard cases:
//    - flush while FULL and in_valid=1 -> next cycle out_valid=0; instruction not accepted.
//    - wb_rd=0 with rs1=0 -> operand 0.
//  - (DECODE_ILLEGAL_EN) instr 0x0000_0000 -> out_illegal=1, out_rd=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// RV32I decode definitions: opcodes, immediate formats, stage state and the decoded bundle.
// decode_stage uses instr_illegal() only when DECODE_ILLEGAL_EN is defined.
package rv32i_pkg;

    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef enum logic {
        EMPTY,
        FULL
    } stage_state_e;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        illegal;
    } decode_bundle_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: t = IMM_I;
            STORE:                                t = IMM_S;
            BRANCH:                               t = IMM_B;
            LUI, AUIPC:                           t = IMM_U;
            JAL:                                  t = IMM_J;
            default:                              t = IMM_NONE;
        endcase
        return t;
    endfunction

    function automatic logic writes_rd(input logic [6:0] opcode);
        return !(opcode == STORE || opcode == BRANCH ||
                 opcode == MISC_MEM || opcode == SYSTEM);
    endfunction

    function automatic logic instr_illegal(input logic [31:0] instr);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = instr[14:12];
        f7  = instr[31:25];
        bad = (instr[1:0] != 2'b11);
        case (instr[6:0])
            LUI, AUIPC, JAL: bad = bad;
            JALR:            bad = bad || (f3 != 3'd0);
            BRANCH:          bad = bad || (f3 == 3'd2) || (f3 == 3'd3);
            LOAD:            bad = bad || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            STORE:           bad = bad || (f3 > 3'd2);
            OP_IMM: begin
                if (f3 == 3'd1)
                    bad = bad || (f7 != 7'h00);
                else if (f3 == 3'd5)
                    bad = bad || ((f7 != 7'h00) && (f7 != 7'h20));
            end
            OP:              bad = bad || ((f7 != 7'h00) && (f7 != 7'h20));
            MISC_MEM:        bad = bad || (f3 > 3'd1);
            SYSTEM:          bad = bad || (f3 == 3'd4);
            default:         bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; IMM_NONE yields zero.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_type_e   imm_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry valid/ready buffer with write-back bypass over a registered-read regfile.
// Define DECODE_ILLEGAL_EN to add the out_illegal port and illegal-encoding detection.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            rstN,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_data1,
    input  logic [XLEN-1:0] rf_data2,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_val,
    output logic [XLEN-1:0] out_rs2_val,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7b5
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic            out_illegal
`endif
);

    stage_state_e    state;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            hit1_q, hit2_q;
    logic            zero1_q, zero2_q;
    logic [XLEN-1:0] wb_data_q;
    logic            accept;
    imm_type_e       imm_type;
    logic [31:0]     imm_val;
    decode_bundle_t  dec;

    assign in_ready = !flush && ((state == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;

    // Register addresses follow the incoming instruction on accept, otherwise the held one,
    // so a stalled bundle keeps re-reading the regfile and picks up later writes.
    assign rf_rs1 = accept ? in_instr[19:15] : instr_q[19:15];
    assign rf_rs2 = accept ? in_instr[24:20] : instr_q[24:20];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= EMPTY;
            instr_q   <= '0;
            pc_q      <= RESET_PC;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
            zero1_q   <= 1'b1;
            zero2_q   <= 1'b1;
            wb_data_q <= '0;
        end else begin
            // The regfile read launched on this edge misses a same-edge write; remember it.
            hit1_q    <= wb_we && (wb_rd != '0) && (wb_rd == rf_rs1);
            hit2_q    <= wb_we && (wb_rd != '0) && (wb_rd == rf_rs2);
            zero1_q   <= (rf_rs1 == '0);
            zero2_q   <= (rf_rs2 == '0);
            wb_data_q <= wb_data;
            if (accept) begin
                instr_q <= in_instr;
                pc_q    <= in_pc;
            end
            if (flush)
                state <= EMPTY;
            else if (accept)
                state <= FULL;
            else if (out_ready)
                state <= EMPTY;
        end
    end

    assign imm_type = imm_type_of(instr_q[6:0]);

    imm_gen u_imm_gen (
        .instr    (instr_q),
        .imm_type (imm_type),
        .imm      (imm_val)
    );

    always_comb begin
        dec          = '0;
        dec.imm      = imm_val;
        dec.opcode   = instr_q[6:0];
        dec.funct3   = instr_q[14:12];
        dec.funct7b5 = instr_q[30];
`ifdef DECODE_ILLEGAL_EN
        dec.illegal  = instr_illegal(instr_q);
`else
        dec.illegal  = 1'b0;
`endif
        dec.rd       = (writes_rd(instr_q[6:0]) && !dec.illegal) ? instr_q[11:7] : '0;
    end

    assign out_valid    = (state == FULL);
    assign out_pc       = pc_q;
    assign out_rs1_val  = zero1_q ? '0 : (hit1_q ? wb_data_q : rf_data1);
    assign out_rs2_val  = zero2_q ? '0 : (hit2_q ? wb_data_q : rf_data2);
    assign out_imm      = dec.imm;
    assign out_rd       = dec.rd;
    assign out_opcode   = dec.opcode;
    assign out_funct3   = dec.funct3;
    assign out_funct7b5 = dec.funct7b5;
`ifdef DECODE_ILLEGAL_EN
    assign out_illegal  = dec.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a registered-read register file model (x0 hardwired).
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rstN;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7b5;
`ifdef DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] regs [32];
    logic [31:0] stream [4];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rstN         (rstN),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_data1     (rf_data1),
        .rf_data2     (rf_data2),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rs1_val  (out_rs1_val),
        .out_rs2_val  (out_rs2_val),
        .out_imm      (out_imm),
        .out_rd       (out_rd),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7b5 (out_funct7b5)
`ifdef DECODE_ILLEGAL_EN
        ,
        .out_illegal  (out_illegal)
`endif
    );

    // Register file: read data registered from the pre-edge contents; a same-edge write is not seen.
    always @(posedge clk) begin
        rf_data1 <= (rf_rs1 == 5'd0) ? 32'h0 : regs[rf_rs1];
        rf_data2 <= (rf_rs2 == 5'd0) ? 32'h0 : regs[rf_rs2];
        if (wb_we && wb_rd != 5'd0)
            regs[wb_rd] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        for (int i = 0; i < 4; i++)
            stream[i] = ((i + 1) << 20) | ((10 + i) << 7) | 32'h13;
        rf_data1 = 32'h0; rf_data2 = 32'h0;
        rstN = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  {31'b0, out_valid}, 32'h0);
        check("rst_ready",  {31'b0, in_ready},  32'h1);
        check("rst_pc",     out_pc,             RPC);
        check("rst_imm",    out_imm,            32'h0);
        check("rst_rd",     {27'b0, out_rd},    32'h0);
        check("rst_rs1",    out_rs1_val,        32'h0);
        check("rst_opcode", {25'b0, out_opcode}, 32'h0);
        rstN = 1'b1;

        // x5 = 0x1234, then addi x6,x5,1
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
        step();
        wb_we = 1'b0;
        in_valid = 1'b1; in_instr = 32'h0012_8313; in_pc = 32'h1000;
        step();
        in_valid = 1'b0;
        check("addi_valid", {31'b0, out_valid}, 32'h1);
        check("addi_rs1",   out_rs1_val,        32'h1234);
        check("addi_imm",   out_imm,            32'h1);
        check("addi_rd",    {27'b0, out_rd},    32'h6);
        check("addi_pc",    out_pc,             32'h1000);

        // add x7,x5,x5 accepted on the same edge as x5 <= 0xBEEF
        in_valid = 1'b1; in_instr = 32'h0052_83B3; in_pc = 32'h1004;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBEEF;
        step();
        in_valid = 1'b0; wb_we = 1'b0;
        check("byp_rs1", out_rs1_val,     32'hBEEF);
        check("byp_rs2", out_rs2_val,     32'hBEEF);
        check("byp_rd",  {27'b0, out_rd}, 32'h7);
        check("byp_imm", out_imm,         32'h0);

        // Three stalled cycles, x5 <= 0x55 during the second
        out_ready = 1'b0; in_valid = 1'b1; in_instr = stream[0]; in_pc = 32'h2000;
        #1;
        check("stall_inready0", {31'b0, in_ready}, 32'h0);
        step();
        check("stall1_valid", {31'b0, out_valid}, 32'h1);
        check("stall1_pc",    out_pc,             32'h1004);
        check("stall1_rs1",   out_rs1_val,        32'hBEEF);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        step();
        wb_we = 1'b0;
        check("stall2_rs1", out_rs1_val, 32'h55);
        check("stall2_rs2", out_rs2_val, 32'h55);
        check("stall2_pc",  out_pc,      32'h1004);
        step();
        check("stall3_rs1",     out_rs1_val,        32'h55);
        check("stall3_inready", {31'b0, in_ready},  32'h0);
        check("stall3_rd",      {27'b0, out_rd},    32'h7);

        // Back-to-back stream
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = stream[i]; in_pc = 32'h2000 + 4 * i;
            #1;
            check("strm_inready", {31'b0, in_ready}, 32'h1);
            step();
            check("strm_valid", {31'b0, out_valid}, 32'h1);
            check("strm_pc",    out_pc,             32'h2000 + 4 * i);
            check("strm_imm",   out_imm,            i + 1);
            check("strm_rd",    {27'b0, out_rd},    10 + i);
        end

        // sw x2,-4(x1) then jal x1,+2048
        in_instr = 32'hFE20_AE23; in_pc = 32'h3000;
        step();
        check("sw_imm",    out_imm,             32'hFFFF_FFFC);
        check("sw_rd",     {27'b0, out_rd},     32'h0);
        check("sw_funct3", {29'b0, out_funct3}, 32'h2);
        in_instr = 32'h0010_00EF; in_pc = 32'h3004;
        step();
        check("jal_imm", out_imm,         32'h800);
        check("jal_rd",  {27'b0, out_rd}, 32'h1);
        check("jal_pc",  out_pc,          32'h3004);

        // Flush while FULL with a valid instruction offered
        in_instr = 32'h0070_0493; in_pc = 32'h4000; flush = 1'b1;
        #1;
        check("flush_inready", {31'b0, in_ready}, 32'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'h0);
        check("flush_pc",    out_pc,             32'h3004);
        step();
        check("flush_idle", {31'b0, out_valid}, 32'h0);

        // addi x9,x0,7 with a same-edge write to x0
        in_valid = 1'b1; in_instr = 32'h0070_0493; in_pc = 32'h5000;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        step();
        in_valid = 1'b0; wb_we = 1'b0;
        check("x0_rs1",   out_rs1_val,        32'h0);
        check("x0_rd",    {27'b0, out_rd},    32'h9);
        check("x0_valid", {31'b0, out_valid}, 32'h1);
`ifdef DECODE_ILLEGAL_EN
        check("legal_flag", {31'b0, out_illegal}, 32'h0);
        in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h6000;
        step();
        in_valid = 1'b0;
        check("illegal_flag", {31'b0, out_illegal}, 32'h1);
        check("illegal_rd",   {27'b0, out_rd},      32'h0);
`endif

        // Reset while holding an instruction
        in_valid = 1'b1; in_instr = stream[1]; in_pc = 32'h7000;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        rstN = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_pc",    out_pc,             RPC);
        check("mid_rst_rd",    {27'b0, out_rd},    32'h0);
        rstN = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
